// File: rtl/spi_sub.sv
// rtl/spi_sub.sv - SPI subordinate (modes 0..3, byte framing, tx holding buffer); option macro SPI_SUB_MSB_FIRST_EN
module spi_sub (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_miso,
    output logic       o_miso_oe,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_tx_underrun
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // synchronizer stages; sclk_s3_q is the delayed copy used for edge detection
    logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic       cs_s1_q, cs_s2_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic [1:0] mode_q;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    // only seven bits of history are needed; the eighth arrives with the final sample
    logic [6:0] rx_sh_q, rx_sh_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       load_pend_q, load_pend_d;
    logic       skip_q, skip_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;

    logic       cpol, cpha;
    logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic       sample_edge, shift_edge;
    logic       load;
    logic [7:0] rx_next;
    logic [7:0] tx_shifted;
    logic       miso_bit;

    // bring the asynchronous SPI pins into the i_clk domain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= i_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= i_cs_n;
            cs_s2_q   <= cs_s1_q;
            mosi_s1_q <= i_mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // mode is only allowed to change between transfers (CS deasserted)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q <= 2'b00;
        end else if (cs_s2_q) begin
            mode_q <= i_mode;
        end
    end

    assign cpol        = mode_q[1];
    assign cpha        = mode_q[0];
    assign sclk_rise   = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall   = ~sclk_s2_q & sclk_s3_q;
    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;

`ifdef SPI_SUB_MSB_FIRST_EN
    assign rx_next    = {rx_sh_q, mosi_s2_q};
    assign tx_shifted = {tx_sh_q[6:0], 1'b0};
    assign miso_bit   = tx_sh_q[7];
`else
    assign rx_next    = {mosi_s2_q, rx_sh_q};
    assign tx_shifted = {1'b0, tx_sh_q[7:1]};
    assign miso_bit   = tx_sh_q[0];
`endif

    // framing FSM, bit counter, shift registers and holding buffer next-state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        load_pend_d = load_pend_q;
        skip_d      = skip_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!cs_s2_q) begin
                    state_d     = ST_ACTIVE;
                    cnt_d       = 3'd0;
                    rx_sh_d     = 7'd0;
                    load        = 1'b1;
                    load_pend_d = 1'b0;
                    // CPHA=1: the first leading edge only presents the bit loaded here
                    skip_d      = cpha;
                end
            end
            ST_ACTIVE: begin
                if (cs_s2_q) begin
                    state_d     = ST_IDLE;
                    cnt_d       = 3'd0;
                    tx_sh_d     = 8'd0;
                    rx_sh_d     = 7'd0;
                    load_pend_d = 1'b0;
                    skip_d      = 1'b0;
                end else begin
                    if (sample_edge) begin
`ifdef SPI_SUB_MSB_FIRST_EN
                        rx_sh_d = rx_next[6:0];
`else
                        rx_sh_d = rx_next[7:1];
`endif
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_byte_d   = rx_next;
                            rx_valid_d  = 1'b1;
                            load_pend_d = 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        if (load_pend_q) begin
                            load        = 1'b1;
                            load_pend_d = 1'b0;
                        end else if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            tx_sh_d = tx_shifted;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            tx_sh_d    = buf_full_q ? buf_q : 8'd0;
            underrun_d = ~buf_full_q;
            buf_full_d = 1'b0;
        end
        // a write accepted in the same cycle as an empty-buffer load refills it afterwards
        if (i_tx_valid && !buf_full_q) begin
            buf_d      = i_tx_byte;
            buf_full_d = 1'b1;
        end
    end

    // transfer state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            tx_sh_q     <= 8'd0;
            rx_sh_q     <= 7'd0;
            buf_q       <= 8'd0;
            buf_full_q  <= 1'b0;
            load_pend_q <= 1'b0;
            skip_q      <= 1'b0;
            rx_byte_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            load_pend_q <= load_pend_d;
            skip_q      <= skip_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_miso_oe     = (state_q == ST_ACTIVE);
    assign o_miso        = (state_q == ST_ACTIVE) & miso_bit;
    assign o_tx_ready    = ~buf_full_q;
    assign o_rx_byte     = rx_byte_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_tx_underrun = underrun_q;

endmodule
